calc_exec_seq: RTL and testbench
================================

CALC_EXEC_SEQ -- requirements
Module: calc_exec_seq

Interface
REQ-001 CLK_1K  input  1  system clock, all state on rising edge.
REQ-002 RSTN  input  1  reset, asynchronous, active-low.
REQ-003 start  input  1  request to execute one operation; sampled only in IDLE.
REQ-004 opcode  input  4  4'ha add, 4'hb sub, 4'hc mul, 4'hd div; other values are invalid.
REQ-005 num_a  input  24  operand A, 6 packed BCD digits, MSD in [23:20].
REQ-006 num_b  input  24  operand B, same format.
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 done  output  1  single-cycle pulse, high only in the DONE state.
REQ-009 num_result  output  24  6-digit BCD result; holds its value between DONE pulses.
REQ-010 err  output  1  error flag for the last operation; valid from DONE and held until the next DONE.

Function
REQ-011 States: IDLE, LOAD, EXEC, CONV, DONE; the block SHALL use no other states.
REQ-012 At a rising edge in IDLE with start=1, the block SHALL capture opcode, num_a and num_b internally and enter LOAD; cycle numbering in this document starts at that edge (edge 0).
REQ-013 start SHALL be ignored in every state except IDLE; operand and opcode inputs SHALL be ignored after capture.
REQ-014 LOAD SHALL last exactly 6 cycles, converting one BCD digit per cycle of each operand, MSD first, as acc = acc*10 + digit, into 20-bit binary values.
REQ-015 If any captured digit is greater than 9, or the opcode is invalid, the block SHALL go from LOAD directly to DONE with err=1, so that done is high in cycle 7.
REQ-016 EXEC for add or sub SHALL take 1 cycle; EXEC for mul (20-step shift-add into a 40-bit product) or div (20-step restoring division, quotient kept, remainder discarded) SHALL take 20 cycles.
REQ-017 At the end of EXEC, a result that is negative (sub with A<B), greater than 999999, or a division with B=0 SHALL route to DONE with err=1, skipping CONV.
REQ-018 CONV SHALL convert the binary result to 6-digit BCD by double-dabble in exactly 20 cycles.
REQ-019 done SHALL be high in cycle 28 for successful add/sub, cycle 47 for successful mul/div, cycle 8 for add/sub errors, and cycle 27 for mul/div errors.
REQ-020 On entry to DONE, the block SHALL register num_result (converted value, or 0 when err=1) and err.
REQ-021 DONE SHALL last 1 cycle and then return to IDLE; start high in DONE SHALL be ignored, so the earliest accepted restart is in the first IDLE cycle.
REQ-022 Results of 0, such as 5-5 and 0*n, SHALL be valid with err=0.

Reset
REQ-023 While RSTN=0, the block SHALL hold state=IDLE, busy=0, done=0, num_result=0, err=0, and all internal accumulators and counters at 0.
REQ-024 Reset asserted during any non-IDLE state SHALL abort the operation immediately, with no done pulse.
REQ-025 After RSTN deasserts, the block SHALL accept start at the first rising edge.

Structure
REQ-026 Shared package calc_pkg SHALL hold the opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV, the state encoding, MAX_VAL=999999, and the step counts (LOAD_CYC=6, ITER_CYC=20).
REQ-027 Double-dabble conversion SHALL be a sub-module calc_bin2bcd with ports start, bin[19:0], bcd[23:0] and fin, started on CONV entry.
REQ-028 A single 5-bit step counter SHALL be shared by LOAD, EXEC and CONV.

Verification
REQ-029 add: A=000123, B=000456, op=a -> num_result=000579, err=0, done in cycle 28, busy high in cycles 1-28.
REQ-030 sub and invalid input: A=000012, B=000034, op=b -> err=1, num_result=0, done in cycle 8; A=0000A1, op=a -> err=1, done in cycle 7.
REQ-031 mul: A=000999, B=001001, op=c -> 999999, err=0, done in cycle 47; A=B=001000, op=c -> err=1, done in cycle 27.
REQ-032 div: A=000100, B=000007, op=d -> 000014, done in cycle 47; B=000000 -> err=1, result 0, done in cycle 27.
REQ-033 robustness: start held high continuously -> back-to-back operations separated by one IDLE cycle, with no start accepted while busy; RSTN pulsed low in cycle 15 of a mul -> outputs 0 and no done pulse.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared constants, state encoding and opcode helpers for calc_exec_seq
package calc_pkg;

    // Opcode encoding
    localparam logic [3:0] OP_ADD = 4'ha;
    localparam logic [3:0] OP_SUB = 4'hb;
    localparam logic [3:0] OP_MUL = 4'hc;
    localparam logic [3:0] OP_DIV = 4'hd;

    // Largest value representable in 6 BCD digits
    localparam int unsigned MAX_VAL  = 999999;

    // Step counts: one cycle per BCD digit in LOAD, one per bit for mul/div/conv
    localparam int unsigned LOAD_CYC = 6;
    localparam int unsigned ITER_CYC = 20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXEC,
        ST_CONV,
        ST_DONE
    } state_t;

    function automatic logic op_valid(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // Multi-cycle operations iterate once per result bit
    function automatic logic op_iter(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/calc_exec_seq_if.sv
// rtl/calc_exec_seq_if.sv - request/result bundle between a requester and calc_exec_seq
// Signals:
//   start      : request one operation (only honoured while the executor is idle)
//   opcode     : operation select (add/sub/mul/div)
//   num_a/b    : 6-digit packed BCD operands, MSD in [23:20]
//   busy       : executor not idle
//   done       : one-cycle completion pulse
//   num_result : 6-digit packed BCD result, held between completions
//   err        : error flag of the last completed operation
interface calc_exec_seq_if;

    logic        start;
    logic [3:0]  opcode;
    logic [23:0] num_a;
    logic [23:0] num_b;
    logic        busy;
    logic        done;
    logic [23:0] num_result;
    logic        err;

    modport master (
        output start, opcode, num_a, num_b,
        input  busy, done, num_result, err
    );

    modport slave (
        input  start, opcode, num_a, num_b,
        output busy, done, num_result, err
    );

endinterface

// File: rtl/calc_bin2bcd.sv
// rtl/calc_bin2bcd.sv - 20-bit binary to 6-digit BCD double-dabble converter, 20 cycles
// Ports:
//   CLK_1K : clock, rising edge
//   RSTN   : asynchronous active-low reset
//   start  : load bin and perform the first shift step in the same cycle
//   bin    : binary value to convert (must be <= 999999 for a meaningful result)
//   bcd    : converted value, valid while fin is high
//   fin    : conversion complete; stays high until the next start
module calc_bin2bcd (
    input  logic        CLK_1K,
    input  logic        RSTN,
    input  logic        start,
    input  logic [19:0] bin,
    output logic [23:0] bcd,
    output logic        fin
);

    // Remaining input bits followed by a marker 1. The marker walks up one
    // position per step; reaching bit 19 means all 20 bits have been shifted
    // in, so no separate step counter is needed.
    logic [19:0] sh;
    logic [23:0] bcd_r;
    logic [23:0] adj;

    function automatic logic [23:0] add3(input logic [23:0] v);
        logic [23:0] r;
        r = v;
        for (int i = 0; i < 6; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign adj = add3(bcd_r);
    assign fin = (sh == 20'h80000);
    assign bcd = bcd_r;

    always_ff @(posedge CLK_1K or negedge RSTN) begin
        if (!RSTN) begin
            sh    <= '0;
            bcd_r <= '0;
        end else if (start) begin
            // BCD register is empty, so the first step needs no adjust
            bcd_r <= {23'd0, bin[19]};
            sh    <= {bin[18:0], 1'b1};
        end else if (sh != 20'd0 && !fin) begin
            bcd_r <= (adj << 1) | {23'd0, sh[19]};
            sh    <= sh << 1;
        end
    end

endmodule

// File: rtl/calc_exec_seq.sv
// rtl/calc_exec_seq.sv - sequential BCD calculator: BCD->binary load, add/sub/mul/div, binary->BCD
// Ports:
//   CLK_1K : clock, rising edge
//   RSTN   : asynchronous active-low reset, aborts any operation in flight
//   bus    : calc_exec_seq_if.slave (start/opcode/num_a/num_b in, busy/done/num_result/err out)
module calc_exec_seq
    import calc_pkg::*;
(
    input  logic            CLK_1K,
    input  logic            RSTN,
    calc_exec_seq_if.slave  bus
);

    state_t      state;
    logic [4:0]  step;          // shared by LOAD, EXEC and CONV
    logic [3:0]  op_cap;
    logic [23:0] a_cap;         // shifted left one digit per LOAD cycle
    logic [23:0] b_cap;
    logic [19:0] a_bin;         // also the dividend shifter during div
    logic [19:0] b_bin;         // also the multiplier shifter during mul
    logic        bad_digit;
    logic [39:0] prod;
    logic [19:0] rem;
    logic [19:0] quo;

    logic        busy_r;
    logic        done_r;
    logic        err_r;
    logic [23:0] result_r;

    // LOAD datapath
    logic [3:0]  dig_a;
    logic [3:0]  dig_b;
    logic        bad_now;

    assign dig_a   = a_cap[23:20];
    assign dig_b   = b_cap[23:20];
    assign bad_now = bad_digit || (dig_a > 4'd9) || (dig_b > 4'd9);

    // EXEC datapath: mul is MSB-first shift-add, div is restoring division.
    // The final step's value is used combinationally so the error check and
    // conversion start happen on the same edge that completes EXEC.
    logic [39:0] mul_next;
    logic [20:0] rem_sh;
    logic        rem_ge;
    logic [19:0] rem_next;
    logic [19:0] quo_next;
    logic [20:0] sum_ab;

    assign mul_next = (prod << 1) + (b_bin[19] ? {20'd0, a_bin} : 40'd0);
    assign rem_sh   = {rem, a_bin[19]};
    assign rem_ge   = (rem_sh >= {1'b0, b_bin});
    assign rem_next = rem_ge ? 20'(rem_sh - {1'b0, b_bin}) : 20'(rem_sh);
    assign quo_next = {quo[18:0], rem_ge};
    assign sum_ab   = {1'b0, a_bin} + {1'b0, b_bin};

    logic [39:0] res_wide;
    logic        res_neg;
    logic        res_div0;
    logic        exec_err;
    logic        exec_last;
    logic        conv_start;
    logic [23:0] conv_bcd;
    logic        conv_fin;

    always_comb begin
        res_wide = 40'd0;
        res_neg  = 1'b0;
        res_div0 = 1'b0;
        case (op_cap)
            OP_ADD: res_wide = {19'd0, sum_ab};
            OP_SUB: begin
                res_wide = {20'd0, a_bin - b_bin};
                res_neg  = (a_bin < b_bin);
            end
            OP_MUL: res_wide = mul_next;
            OP_DIV: begin
                res_wide = {20'd0, quo_next};
                res_div0 = (b_bin == 20'd0);
            end
            default: ;
        endcase
    end

    assign exec_err   = res_neg || res_div0 || (res_wide > 40'(MAX_VAL));
    assign exec_last  = !op_iter(op_cap) || (step == 5'(ITER_CYC - 1));
    assign conv_start = (state == ST_EXEC) && exec_last && !exec_err;

    calc_bin2bcd u_bin2bcd (
        .CLK_1K (CLK_1K),
        .RSTN   (RSTN),
        .start  (conv_start),
        .bin    (res_wide[19:0]),
        .bcd    (conv_bcd),
        .fin    (conv_fin)
    );

    always_ff @(posedge CLK_1K or negedge RSTN) begin
        if (!RSTN) begin
            state     <= ST_IDLE;
            step      <= '0;
            op_cap    <= '0;
            a_cap     <= '0;
            b_cap     <= '0;
            a_bin     <= '0;
            b_bin     <= '0;
            bad_digit <= 1'b0;
            prod      <= '0;
            rem       <= '0;
            quo       <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            result_r  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_cap    <= bus.opcode;
                        a_cap     <= bus.num_a;
                        b_cap     <= bus.num_b;
                        a_bin     <= '0;
                        b_bin     <= '0;
                        bad_digit <= 1'b0;
                        prod      <= '0;
                        rem       <= '0;
                        quo       <= '0;
                        step      <= '0;
                        busy_r    <= 1'b1;
                        state     <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    a_cap     <= a_cap << 4;
                    b_cap     <= b_cap << 4;
                    a_bin     <= a_bin * 20'd10 + {16'd0, dig_a};
                    b_bin     <= b_bin * 20'd10 + {16'd0, dig_b};
                    bad_digit <= bad_now;
                    if (step == 5'(LOAD_CYC - 1)) begin
                        step <= '0;
                        if (bad_now || !op_valid(op_cap)) begin
                            state    <= ST_DONE;
                            done_r   <= 1'b1;
                            err_r    <= 1'b1;
                            result_r <= '0;
                        end else begin
                            state <= ST_EXEC;
                        end
                    end else begin
                        step <= step + 5'd1;
                    end
                end

                ST_EXEC: begin
                    if (op_cap == OP_MUL) begin
                        prod  <= mul_next;
                        b_bin <= b_bin << 1;
                    end
                    if (op_cap == OP_DIV) begin
                        rem   <= rem_next;
                        quo   <= quo_next;
                        a_bin <= a_bin << 1;
                    end
                    if (exec_last) begin
                        step <= '0;
                        if (exec_err) begin
                            state    <= ST_DONE;
                            done_r   <= 1'b1;
                            err_r    <= 1'b1;
                            result_r <= '0;
                        end else begin
                            state <= ST_CONV;
                        end
                    end else begin
                        step <= step + 5'd1;
                    end
                end

                ST_CONV: begin
                    if (step == 5'(ITER_CYC - 1)) begin
                        // Converter finishes one cycle early; fin guards against
                        // publishing a half-converted value.
                        step     <= '0;
                        state    <= ST_DONE;
                        done_r   <= 1'b1;
                        err_r    <= !conv_fin;
                        result_r <= conv_fin ? conv_bcd : 24'd0;
                    end else begin
                        step <= step + 5'd1;
                    end
                end

                ST_DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= ST_IDLE;
                end

                default: begin
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.err        = err_r;
    assign bus.num_result = result_r;

endmodule

// File: tb/tb_calc_exec_seq.sv
// tb/tb_calc_exec_seq.sv - scoreboard bench for calc_exec_seq
module tb_calc_exec_seq;

    logic CLK_1K;
    logic RSTN;

    calc_exec_seq_if bus ();

    calc_exec_seq dut (
        .CLK_1K (CLK_1K),
        .RSTN   (RSTN),
        .bus    (bus)
    );

    initial CLK_1K = 1'b0;
    always #5 CLK_1K = ~CLK_1K;

    typedef struct {
        logic [23:0] res;
        logic        err;
        int          lat;
        int          e0;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [23:0] a;
        logic [23:0] b;
    } vec_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   edge_cnt = 0;
    int   busy_run = 0;
    logic prev_done = 1'b0;

    always @(posedge CLK_1K) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    // Reference: decimal arithmetic on the BCD operands, latency from the op class
    function automatic void model(input logic [3:0] op, input logic [23:0] a,
                                  input logic [23:0] b, output exp_t x);
        longint av, bv, rv;
        logic   bad, iter;
        logic [3:0] d;
        av = 0; bv = 0; rv = 0; bad = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            d = a[4*i +: 4]; bad = bad | (d > 4'd9); av = av * 10 + longint'(d);
            d = b[4*i +: 4]; bad = bad | (d > 4'd9); bv = bv * 10 + longint'(d);
        end
        x.res = 24'd0; x.err = 1'b1; x.e0 = 0; x.lat = 7;
        if (!bad && (op == 4'ha || op == 4'hb || op == 4'hc || op == 4'hd)) begin
            iter = (op == 4'hc) || (op == 4'hd);
            case (op)
                4'ha:    rv = av + bv;
                4'hb:    rv = av - bv;
                4'hc:    rv = av * bv;
                default: rv = (bv == 0) ? -1 : av / bv;
            endcase
            if (rv < 0 || rv > 999999) begin
                x.lat = iter ? 27 : 8;
            end else begin
                x.err = 1'b0;
                x.lat = iter ? 47 : 28;
                for (int i = 0; i < 6; i++) begin
                    x.res[4*i +: 4] = 4'(rv % 10);
                    rv = rv / 10;
                end
            end
        end
    endfunction

    function automatic logic [23:0] rand_bcd(input int nd);
        logic [23:0] r;
        r = 24'd0;
        for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge CLK_1K);
        while ((bus.busy || bus.done) && n < 100) begin
            @(negedge CLK_1K);
            n++;
        end
        chk("idle_wait", 64'(n < 100), 64'(1));
    endtask

    task automatic scramble();
        bus.opcode = 4'($urandom);
        bus.num_a  = 24'($urandom);
        bus.num_b  = 24'($urandom);
    endtask

    task automatic do_op(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b);
        exp_t x;
        wait_idle();
        model(op, a, b, x);
        x.e0 = edge_cnt + 1;
        sb.push_back(x);
        bus.start = 1'b1; bus.opcode = op; bus.num_a = a; bus.num_b = b;
        @(posedge CLK_1K);
        #1;
        bus.start = 1'b0;
        scramble();
    endtask

    // start held high across two operations: second accepted in the IDLE cycle after DONE
    task automatic do_b2b(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b);
        exp_t x, y;
        wait_idle();
        model(op, a, b, x);
        x.e0 = edge_cnt + 1;
        y = x;
        y.e0 = x.e0 + x.lat + 1;
        sb.push_back(x);
        sb.push_back(y);
        bus.start = 1'b1; bus.opcode = op; bus.num_a = a; bus.num_b = b;
        repeat (x.lat + 2) @(posedge CLK_1K);
        #1;
        bus.start = 1'b0;
        scramble();
    endtask

    always @(negedge CLK_1K) begin
        exp_t x;
        if (!RSTN) begin
            busy_run  = 0;
            prev_done = 1'b0;
        end else begin
            if (bus.busy) busy_run++; else busy_run = 0;
            if (bus.done) begin
                chk("done_pulse", 64'(prev_done), 64'(0));
                chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    x = sb.pop_front();
                    chk("result", 64'(bus.num_result), 64'(x.res));
                    chk("err", 64'(bus.err), 64'(x.err));
                    chk("latency", 64'(edge_cnt - x.e0 + 1), 64'(x.lat));
                    chk("busy_cycles", 64'(busy_run), 64'(x.lat));
                end
            end
            prev_done = bus.done;
        end
    end

    vec_t vecs[12] = '{
        '{4'ha, 24'h000123, 24'h000456},
        '{4'hb, 24'h000012, 24'h000034},
        '{4'ha, 24'h0000A1, 24'h000456},
        '{4'hc, 24'h000999, 24'h001001},
        '{4'hc, 24'h001000, 24'h001000},
        '{4'hd, 24'h000100, 24'h000007},
        '{4'hd, 24'h000100, 24'h000000},
        '{4'hb, 24'h000005, 24'h000005},
        '{4'hc, 24'h000000, 24'h123456},
        '{4'h3, 24'h000001, 24'h000002},
        '{4'ha, 24'h999999, 24'h000001},
        '{4'hd, 24'h999999, 24'h000001}
    };

    initial begin
        exp_t x;
        int   n;
        RSTN       = 1'b0;
        bus.start  = 1'b0;
        bus.opcode = 4'h0;
        bus.num_a  = 24'd0;
        bus.num_b  = 24'd0;
        repeat (3) @(negedge CLK_1K);
        chk("rst_busy",   64'(bus.busy),       64'(0));
        chk("rst_done",   64'(bus.done),       64'(0));
        chk("rst_result", 64'(bus.num_result), 64'(0));
        chk("rst_err",    64'(bus.err),        64'(0));
        RSTN = 1'b1;

        foreach (vecs[i]) do_op(vecs[i].op, vecs[i].a, vecs[i].b);

        for (int i = 0; i < 6; i++) begin
            do_op(4'(10 + $urandom_range(0, 3)), rand_bcd(4), rand_bcd(3));
        end

        do_b2b(4'ha, 24'h000123, 24'h000456);

        // Reset in cycle 15 of a multiply: outputs clear, no done pulse
        wait_idle();
        bus.start = 1'b1; bus.opcode = 4'hc; bus.num_a = 24'h000999; bus.num_b = 24'h001001;
        @(posedge CLK_1K);
        #1;
        bus.start = 1'b0;
        repeat (14) @(posedge CLK_1K);
        #2;
        RSTN = 1'b0;
        #1;
        chk("abort_busy",   64'(bus.busy),       64'(0));
        chk("abort_done",   64'(bus.done),       64'(0));
        chk("abort_result", 64'(bus.num_result), 64'(0));
        chk("abort_err",    64'(bus.err),        64'(0));
        @(negedge CLK_1K);
        @(negedge CLK_1K);
        // start already high when reset releases: accepted at the first edge
        model(4'hb, 24'h000005, 24'h000005, x);
        x.e0 = edge_cnt + 1;
        sb.push_back(x);
        bus.start = 1'b1; bus.opcode = 4'hb; bus.num_a = 24'h000005; bus.num_b = 24'h000005;
        RSTN = 1'b1;
        @(posedge CLK_1K);
        #1;
        bus.start = 1'b0;
        scramble();

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge CLK_1K);
            n++;
        end
        chk("drain", 64'(sb.size()), 64'(0));
        repeat (5) @(negedge CLK_1K);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
